// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter
//   Merges two register-file write requesters (A: ALU writeback, B: memory
//   load) onto one registered register-file write port. Each requester has a
//   one-entry holding buffer. Each cycle, one full buffer is granted, chosen
//   by age and then by a round-robin pointer on ties. Writes to register 0
//   are consumed and never emitted.
// Ports
//   CLK, Reset            clock, synchronous active-high reset
//   ValidA/AddrA/DataA    requester A write request; ReadyA = A buffer empty
//   ValidB/AddrB/DataB    requester B write request; ReadyB = B buffer empty
//   RegWrite/WrAddr/writedata  registered register-file write port
//   Pending               bit i: a write to register i is buffered or outgoing
//   Idle                  nothing buffered and no write outgoing

package rpa_pkg;
  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } req_t;
endpackage

// One-entry holding buffer for a single requester.
module rpa_hold_buf
  import rpa_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  req_t req,
  input  logic grant,        // this entry drains on this edge
  input  logic other_full,
  input  logic other_grant,
  output logic full,
  output req_t ent,
  output logic young         // captured while the other entry stayed full
);
  logic full_q, full_d;
  req_t ent_q, ent_d;
  logic young_q, young_d;

  always_comb begin
    full_d  = full_q;
    ent_d   = ent_q;
    young_d = young_q;
    if (grant) begin
      full_d  = 1'b0;
      young_d = 1'b0;
    end else if (valid && !full_q) begin
      full_d  = 1'b1;
      ent_d   = req;
      young_d = other_full && !other_grant;
    end
    // Once the older entry leaves, nothing is older than this one.
    if (other_grant) young_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      ent_q   <= '0;
      young_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ent_q   <= ent_d;
      young_q <= young_d;
    end
  end

  assign full  = full_q;
  assign ent   = ent_q;
  assign young = young_q;
endmodule

module reg_port_arbiter
  import rpa_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        ValidA,
  input  logic [3:0]  AddrA,
  input  logic [15:0] DataA,
  output logic        ReadyA,
  input  logic        ValidB,
  input  logic [3:0]  AddrB,
  input  logic [15:0] DataB,
  output logic        ReadyB,
  output logic        RegWrite,
  output logic [3:0]  WrAddr,
  output logic [15:0] writedata,
  output logic [15:0] Pending,
  output logic        Idle
);
  // index 0 = A, index 1 = B
  logic [1:0] valid, full, young, grant;
  req_t [1:0] req, ent;
  req_t       gnt_ent;

  logic        rr_q, rr_d;            // 0: A wins next tie, 1: B
  logic        reg_write_q, reg_write_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wdata_q, wdata_d;

  assign valid = {ValidB, ValidA};
  assign req   = {req_t'{AddrB, DataB}, req_t'{AddrA, DataA}};

  for (genvar i = 0; i < 2; i++) begin : g_buf
    rpa_hold_buf u_buf (
      .clk        (CLK),
      .reset      (Reset),
      .valid      (valid[i]),
      .req        (req[i]),
      .grant      (grant[i]),
      .other_full (full[1-i]),
      .other_grant(grant[1-i]),
      .full       (full[i]),
      .ent        (ent[i]),
      .young      (young[i])
    );
  end

  // Grant selection: older entry first, pointer only breaks true ties.
  always_comb begin
    grant = 2'b00;
    rr_d  = rr_q;
    if (&full) begin
      if (young[1] && !young[0])      grant = 2'b01;
      else if (young[0] && !young[1]) grant = 2'b10;
      else begin
        grant = rr_q ? 2'b10 : 2'b01;
        rr_d  = !rr_q;
      end
    end else if (full[0]) begin
      grant = 2'b01;
    end else if (full[1]) begin
      grant = 2'b10;
    end
  end

  assign gnt_ent = grant[1] ? ent[1] : ent[0];

  // Register 0 is consumed silently; the port keeps its previous addr/data.
  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wdata_d     = wdata_q;
    if ((|grant) && (gnt_ent.addr != 4'd0)) begin
      reg_write_d = 1'b1;
      wr_addr_d   = gnt_ent.addr;
      wdata_d     = gnt_ent.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rr_q        <= 1'b0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < 2; i++)
      if (full[i]) Pending[ent[i].addr] = 1'b1;
    if (reg_write_q) Pending[wr_addr_q] = 1'b1;
    Pending[0] = 1'b0;
  end

  assign ReadyA    = !full[0];
  assign ReadyB    = !full[1];
  assign RegWrite  = reg_write_q;
  assign WrAddr    = wr_addr_q;
  assign writedata = wdata_q;
  assign Idle      = !(|full) && !reg_write_q;
endmodule

// File: tb/tb_reg_port_arbiter.sv
module tb_reg_port_arbiter;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        ValidA, ValidB;
  logic [3:0]  AddrA, AddrB;
  logic [15:0] DataA, DataB;
  logic        ReadyA, ReadyB, RegWrite, Idle;
  logic [3:0]  WrAddr;
  logic [15:0] writedata, Pending;

  int n_vec = 0;
  int n_err = 0;

  reg_port_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
    .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
    .RegWrite(RegWrite), .WrAddr(WrAddr), .writedata(writedata),
    .Pending(Pending), .Idle(Idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [3:0] a, input logic [15:0] d);
    chk({tag, ".rw"}, 32'(RegWrite), 32'(rw));
    if (rw) begin
      chk({tag, ".addr"}, 32'(WrAddr), 32'(a));
      chk({tag, ".data"}, 32'(writedata), 32'(d));
    end
  endtask

  initial begin
    Reset = 1'b1; ValidA = 0; ValidB = 0;
    AddrA = 0; AddrB = 0; DataA = 0; DataB = 0;
    step(); step();
    Reset = 1'b0;
    chk("rst.readyA", 32'(ReadyA), 1);
    chk("rst.readyB", 32'(ReadyB), 1);
    chk("rst.pending", 32'(Pending), 0);
    chk("rst.idle", 32'(Idle), 1);
    chk("rst.rw", 32'(RegWrite), 0);
    chk("rst.addr", 32'(WrAddr), 0);
    chk("rst.data", 32'(writedata), 0);

    // Single write
    ValidA = 1; AddrA = 4'd1; DataA = 16'h0F0F;
    step();
    ValidA = 0;
    chk("single.pending", 32'(Pending), 32'h0002);
    chk("single.readyA", 32'(ReadyA), 0);
    chk("single.rw0", 32'(RegWrite), 0);
    chk("single.idle0", 32'(Idle), 0);
    step();
    chk_wr("single.wr", 1, 4'd1, 16'h0F0F);
    chk("single.readyA1", 32'(ReadyA), 1);
    step();
    chk("single.rw_end", 32'(RegWrite), 0);
    chk("single.idle", 32'(Idle), 1);
    chk("single.pend_end", 32'(Pending), 0);

    // Simultaneous tie: pointer at A, then B
    for (int r = 0; r < 2; r++) begin
      ValidA = 1; AddrA = 4'd2; DataA = 16'hF0F0;
      ValidB = 1; AddrB = 4'd3; DataB = 16'hAAAA;
      step();
      ValidA = 0; ValidB = 0;
      chk("tie.ready", 32'({ReadyA, ReadyB}), 0);
      chk("tie.pend", 32'(Pending), 32'h000C);
      step();
      if (r == 0) chk_wr("tie0.first", 1, 4'd2, 16'hF0F0);
      else        chk_wr("tie1.first", 1, 4'd3, 16'hAAAA);
      chk("tie.pend_mid", 32'(Pending), 32'h000C);
      step();
      if (r == 0) chk_wr("tie0.second", 1, 4'd3, 16'hAAAA);
      else        chk_wr("tie1.second", 1, 4'd2, 16'hF0F0);
      step();
      chk("tie.idle", 32'(Idle), 1);
    end

    // Age order: B first, A one edge later, same register
    ValidB = 1; AddrB = 4'd5; DataB = 16'h1234;
    step();
    ValidB = 0;
    chk("age.readyA", 32'(ReadyA), 1);
    ValidA = 1; AddrA = 4'd5; DataA = 16'h5678;
    step();
    ValidA = 0;
    chk_wr("age.first", 1, 4'd5, 16'h1234);
    chk("age.pend1", 32'(Pending), 32'h0020);
    step();
    chk_wr("age.second", 1, 4'd5, 16'h5678);
    chk("age.pend2", 32'(Pending), 32'h0020);
    step();
    chk("age.pend_clr", 32'(Pending), 0);
    chk("age.rw_end", 32'(RegWrite), 0);

    // Register 0: consumed, never written, port holds previous values
    ValidA = 1; AddrA = 4'd0; DataA = 16'hFFFF;
    step();
    ValidA = 0;
    chk("r0.pend", 32'(Pending), 0);
    chk("r0.readyA", 32'(ReadyA), 0);
    chk("r0.idle0", 32'(Idle), 0);
    step();
    chk("r0.rw", 32'(RegWrite), 0);
    chk("r0.addr", 32'(WrAddr), 5);
    chk("r0.data", 32'(writedata), 32'h5678);
    chk("r0.pend2", 32'(Pending), 0);
    chk("r0.idle", 32'(Idle), 1);

    // Backpressure: A streams 1..4, holding each value until accepted
    ValidA = 1; AddrA = 4'd7; DataA = 16'd1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp%0d.ready_hi", k), 32'(ReadyA), 1);
      step();
      chk($sformatf("bp%0d.ready_lo", k), 32'(ReadyA), 0);
      chk($sformatf("bp%0d.rw_lo", k), 32'(RegWrite), 0);
      if (k < 4) DataA = 16'(k + 1);
      else ValidA = 0;
      step();
      chk_wr($sformatf("bp%0d.wr", k), 1, 4'd7, 16'(k));
    end
    step();
    chk("bp.rw_end", 32'(RegWrite), 0);
    chk("bp.idle", 32'(Idle), 1);

    // Reset mid-flight with both buffers full; reset beats a new ValidA
    ValidA = 1; AddrA = 4'd9;  DataA = 16'h9999;
    ValidB = 1; AddrB = 4'd10; DataB = 16'hAAAA;
    step();
    chk("mr.ready", 32'({ReadyA, ReadyB}), 0);
    chk("mr.pend", 32'(Pending), 32'h0600);
    ValidB = 0; AddrA = 4'd11; DataA = 16'hBBBB;
    Reset = 1;
    step();
    Reset = 0; ValidA = 0;
    chk("mr.rw", 32'(RegWrite), 0);
    chk("mr.addr", 32'(WrAddr), 0);
    chk("mr.data", 32'(writedata), 0);
    chk("mr.pend0", 32'(Pending), 0);
    chk("mr.idle", 32'(Idle), 1);
    chk("mr.readyAB", 32'({ReadyA, ReadyB}), 32'h3);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mr.nostale%0d", c), 32'({RegWrite, Idle}), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
